// File: rtl/lbs_master_if.sv
// Request/response handshake plus local-bus control/address signals of the
// lbs_master initiator. The bidirectional data bus stays a plain inout port.
interface lbs_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [11:0] lbs_addr;
    logic        lbs_cs_n;
    logic        lbs_rw_n;
    logic        lbs_oe_n;

    // Initiator view: takes requests, drives responses and the bus controls.
    modport master (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata,
        output lbs_addr, lbs_cs_n, lbs_rw_n, lbs_oe_n
    );

    // Counterpart view: requester and bus slave decoder.
    modport slave (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  lbs_addr, lbs_cs_n, lbs_rw_n, lbs_oe_n
    );
endinterface

// File: rtl/lbs_master.sv
// Local-bus initiator: converts one accepted request into a single
// asynchronous bus cycle with programmable setup / strobe / hold lengths.
// All bus outputs come straight from flops so they never glitch.
module lbs_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    lbs_master_if.master  bus,
    inout  wire  [15:0]   lbs_dio
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    // Counter reload values: each phase runs N cycles, counting N-1 down to 0.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic        w_accept;
    logic        w_wr_eff;
    logic        r_wr;
    logic [11:0] r_addr;
    logic [7:0]  r_wdata;

    logic        r_cs_n;
    logic        r_rw_n;
    logic        r_oe_n;
    logic        r_dio_oe;
    logic        r_rsp_valid;
    logic [7:0]  r_rdata;

    logic        w_cs_n_nxt;
    logic        w_rw_n_nxt;
    logic        w_oe_n_nxt;
    logic        w_dio_oe_nxt;
    logic        w_rsp_nxt;
    logic        w_rd_cap;

    // The upper data byte is driven on writes but carries nothing on reads.
    wire         w_unused_dio_hi = &{1'b0, lbs_dio[15:8]};

    assign w_accept      = bus.req_valid && (r_state == ST_IDLE);
    assign bus.req_ready = (r_state == ST_IDLE);

    // State register and phase counter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: walk SETUP -> STROBE -> HOLD, leaving each phase when the counter hits 0.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = STROBE_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so registered outputs line up with the state they belong to.
    always_comb begin
        w_wr_eff     = w_accept ? bus.req_wr : r_wr;
        w_cs_n_nxt   = (w_state_nxt == ST_IDLE);
        w_rw_n_nxt   = !((w_state_nxt == ST_STROBE) && w_wr_eff);
        w_oe_n_nxt   = !((w_state_nxt == ST_STROBE) && !w_wr_eff);
        w_dio_oe_nxt = (w_state_nxt != ST_IDLE) && w_wr_eff;
        w_rsp_nxt    = (r_state == ST_HOLD) && (w_state_nxt == ST_IDLE);
        w_rd_cap     = (r_state == ST_STROBE) && (w_state_nxt == ST_HOLD) && !r_wr;
    end

    // Request capture: fields are frozen from acceptance until the cycle completes.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, because lbs_addr must read 0 out of reset.
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_addr  <= 12'd0;
            r_wdata <= 8'd0;
        end else if (w_accept) begin
            r_wr    <= bus.req_wr;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // Registered bus controls, response pulse and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n      <= 1'b1;
            r_rw_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dio_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'd0;
        end else begin
            r_cs_n      <= w_cs_n_nxt;
            r_rw_n      <= w_rw_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_dio_oe    <= w_dio_oe_nxt;
            r_rsp_valid <= w_rsp_nxt;
            if (w_rd_cap) begin
                r_rdata <= lbs_dio[7:0];
            end
        end
    end

    assign bus.lbs_addr  = r_addr;
    assign bus.lbs_cs_n  = r_cs_n;
    assign bus.lbs_rw_n  = r_rw_n;
    assign bus.lbs_oe_n  = r_oe_n;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign lbs_dio       = r_dio_oe ? {8'h00, r_wdata} : 16'hzzzz;

endmodule

// File: tb/tb_lbs_master.sv
// Self-checking bench for lbs_master: table of single transactions checked
// cycle by cycle, plus back-to-back, busy-disturbance and mid-cycle reset.
module tb_lbs_master;

    localparam int S = 2;
    localparam int P = 4;
    localparam int H = 2;
    localparam int T = S + P + H;
    localparam logic [15:0] KEEP = 16'hA500;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        string       name;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lbs_master_if bif();
    wire  [15:0] lbs_dio;

    // Bench-side bus keeper, active whenever the master is expected to float the bus.
    logic        keep_en = 1'b1;

    // Slave model: byte memory, drives on oe_n, logs a write on rw_n rising while selected.
    logic [7:0]  slv_mem [4096];
    logic        slv_init   = 1'b0;
    logic        prev_rw_n  = 1'b1;
    int          log_cnt    = 0;
    logic [11:0] log_addr   = 12'd0;
    logic [7:0]  log_data   = 8'd0;

    assign lbs_dio = (!bif.lbs_cs_n && !bif.lbs_oe_n) ? {8'hC3, slv_mem[bif.lbs_addr]}
                   : (keep_en ? KEEP : 16'hzzzz);

    always @(posedge clk) begin
        if (!slv_init) begin
            for (int i = 0; i < 4096; i++) slv_mem[i] <= 8'h00;
            slv_mem[12'h805] <= 8'h5A;
            slv_init <= 1'b1;
        end else if (!bif.lbs_cs_n && bif.lbs_rw_n && !prev_rw_n) begin
            slv_mem[bif.lbs_addr] <= lbs_dio[7:0];
            log_cnt  <= log_cnt + 1;
            log_addr <= bif.lbs_addr;
            log_data <= lbs_dio[7:0];
        end
        prev_rw_n <= bif.lbs_rw_n;
    end

    lbs_master #(
        .SETUP_CYC  (S),
        .STROBE_CYC (P),
        .HOLD_CYC   (H)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif),
        .lbs_dio (lbs_dio)
    );

    initial begin
        if (S < 1 || S > 255 || P < 3 || P > 255 || H < 2 || H > 255)
            $fatal(1, "lbs_master timing parameters out of range");
    end

    int          n_cmp   = 0;
    int          n_bad   = 0;
    logic [7:0]  m_rdata = 8'h00;
    vec_t        vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; returns in its rsp_valid cycle (cycle T+1).
    task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_rd, input bit hold_valid, input bit disturb,
                           input string name, output int waited);
        int         log0;
        logic [7:0] rd_old;
        logic [15:0] exp_dio;
        bit         strb;
        bif.req_valid = 1'b1;
        bif.req_wr    = wr;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        waited = 0;
        while (!bif.req_ready && waited < 50) begin
            tick();
            waited++;
        end
        check($sformatf("%s ready", name), bif.req_ready, 1'b1);
        if (wr) keep_en = 1'b0;
        log0   = log_cnt;
        rd_old = m_rdata;
        tick();
        if (!hold_valid) bif.req_valid = 1'b0;
        for (int c = 1; c <= T + 1; c++) begin
            strb = (c >= S + 1) && (c <= S + P);
            check($sformatf("%s c%0d cs_n", name, c), bif.lbs_cs_n, (c > T));
            check($sformatf("%s c%0d rw_n", name, c), bif.lbs_rw_n, !(wr && strb));
            check($sformatf("%s c%0d oe_n", name, c), bif.lbs_oe_n, !(!wr && strb));
            check($sformatf("%s c%0d rsp_valid", name, c), bif.rsp_valid, (c == T + 1));
            check($sformatf("%s c%0d rsp_rdata", name, c), bif.rsp_rdata,
                  (!wr && c > S + P) ? exp_rd : rd_old);
            if (c <= T) check($sformatf("%s c%0d addr", name, c), bif.lbs_addr, addr);
            if (wr && c <= T)  exp_dio = {8'h00, wdata};
            else if (!wr && strb) exp_dio = {8'hC3, exp_rd};
            else               exp_dio = KEEP;
            check($sformatf("%s c%0d dio", name, c), lbs_dio, exp_dio);
            if (c == T + 1) begin
                check($sformatf("%s log_cnt", name), log_cnt, log0 + (wr ? 1 : 0));
                if (wr) begin
                    check($sformatf("%s log_addr", name), log_addr, addr);
                    check($sformatf("%s log_data", name), log_data, wdata);
                end
            end
            if (disturb && c == S + 2) begin
                bif.req_valid = 1'b1;
                bif.req_wr    = ~wr;
                bif.req_addr  = ~addr;
                bif.req_wdata = ~wdata;
                check($sformatf("%s busy ready", name), bif.req_ready, 1'b0);
            end
            if (disturb && c == S + 3) bif.req_valid = 1'b0;
            if (c == T) keep_en = 1'b1;
            if (c <= T) tick();
        end
        if (!wr) m_rdata = exp_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{1'b1, 12'h1A5, 8'h3C, 8'h00, "wr_1a5"};
        vecs[1] = '{1'b0, 12'h805, 8'h00, 8'h5A, "rd_805"};
        vecs[2] = '{1'b1, 12'h333, 8'h77, 8'h00, "wr_333"};
        vecs[3] = '{1'b0, 12'h1A5, 8'h00, 8'h3C, "rd_1a5"};
        vecs[4] = '{1'b1, 12'hFFF, 8'hFF, 8'h00, "wr_fff"};
        vecs[5] = '{1'b0, 12'hFFF, 8'h00, 8'hFF, "rd_fff"};
        vecs[6] = '{1'b0, 12'h000, 8'h00, 8'h00, "rd_000"};

        bif.req_valid = 1'b0;
        bif.req_wr    = 1'b0;
        bif.req_addr  = 12'h000;
        bif.req_wdata = 8'h00;

        // Reset values.
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst cs_n", bif.lbs_cs_n, 1'b1);
        check("rst rw_n", bif.lbs_rw_n, 1'b1);
        check("rst oe_n", bif.lbs_oe_n, 1'b1);
        check("rst rsp_valid", bif.rsp_valid, 1'b0);
        check("rst rsp_rdata", bif.rsp_rdata, 8'h00);
        check("rst addr", bif.lbs_addr, 12'h000);
        check("rst dio", lbs_dio, KEEP);
        rst_n = 1'b1;
        tick();
        check("rst req_ready", bif.req_ready, 1'b1);

        // Single transactions from the table.
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0, 1'b0,
                    vecs[i].name, w);
            tick();
        end

        // Back-to-back with req_valid held: second request taken in the rsp_valid cycle.
        run_txn(1'b1, 12'h210, 8'h11, 8'h00, 1'b1, 1'b0, "b2b_wr", w);
        check("b2b rsp ready", bif.req_ready, 1'b1);
        run_txn(1'b0, 12'h210, 8'h00, 8'h11, 1'b0, 1'b0, "b2b_rd", w);
        check("b2b no wait", w, 0);
        tick();

        // Request fields and req_valid wiggled while busy.
        run_txn(1'b1, 12'h0A0, 8'h5C, 8'h00, 1'b0, 1'b1, "busy_wr", w);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("busy after c%0d cs_n", c), bif.lbs_cs_n, 1'b1);
            check($sformatf("busy after c%0d rsp_valid", c), bif.rsp_valid, 1'b0);
        end

        // Reset in the middle of a write strobe.
        bif.req_valid = 1'b1;
        bif.req_wr    = 1'b1;
        bif.req_addr  = 12'h2B6;
        bif.req_wdata = 8'h99;
        keep_en = 1'b0;
        tick();
        bif.req_valid = 1'b0;
        repeat (S + 1) tick();
        check("abort in strobe rw_n", bif.lbs_rw_n, 1'b0);
        #2;
        rst_n   = 1'b0;
        keep_en = 1'b1;
        #1;
        check("abort cs_n", bif.lbs_cs_n, 1'b1);
        check("abort rw_n", bif.lbs_rw_n, 1'b1);
        check("abort oe_n", bif.lbs_oe_n, 1'b1);
        check("abort dio", lbs_dio, KEEP);
        check("abort rsp_valid", bif.rsp_valid, 1'b0);
        check("abort rsp_rdata", bif.rsp_rdata, 8'h00);
        m_rdata = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < T + 2; c++) begin
            tick();
            check($sformatf("post-rst c%0d rsp_valid", c), bif.rsp_valid, 1'b0);
            check($sformatf("post-rst c%0d cs_n", c), bif.lbs_cs_n, 1'b1);
        end
        run_txn(1'b0, 12'h210, 8'h00, 8'h11, 1'b0, 1'b0, "post_rst_rd", w);
        tick();
        run_txn(1'b1, 12'h2B6, 8'hE1, 8'h00, 1'b0, 1'b0, "post_rst_wr", w);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
